// File: rtl/parking_gate_if.sv
// parking_gate_if: gate sensor and slot manager signals seen by parking_gate_controller
interface parking_gate_if #(parameter int NUM_SLOTS = 4);
    logic                 entry_req;
    logic                 exit_req;
    logic [3:0]           exit_slot;
    logic [NUM_SLOTS-1:0] slot_status;
    logic                 gate_open;
    logic [3:0]           slot_update;
    logic                 timer_status;
    logic                 upd_valid;
    logic [3:0]           assigned_slot;
    logic                 entry_denied;
    logic                 exit_error;
    logic                 busy;
    modport master (
        output entry_req, exit_req, exit_slot, slot_status,
        input  gate_open, slot_update, timer_status, upd_valid, assigned_slot, entry_denied, exit_error, busy
    );
    modport slave (
        input  entry_req, exit_req, exit_slot, slot_status,
        output gate_open, slot_update, timer_status, upd_valid, assigned_slot, entry_denied, exit_error, busy
    );
endinterface

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: gate sequencing and slot allocation; PARK_ROUND_ROBIN_EN selects rotating allocation
module parking_gate_controller #(
    parameter int NUM_SLOTS        = 4,
    parameter int GATE_OPEN_CYCLES = 8
) (
    input logic           clk,
    input logic           reset,
    parking_gate_if.slave bus
);
    localparam int CW = $clog2(GATE_OPEN_CYCLES + 1);
    localparam logic [1:0] IDLE = 2'd0, OPEN = 2'd1, COMMIT = 2'd2, SETTLE = 2'd3;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          dir;
    logic [3:0]    idx;
    logic [15:0]   occ;
    logic [4:0]    j;
    logic [3:0]    free_idx;
    logic [3:0]    ptr;
    logic          exit_ok;
    logic          lot_full;
    logic          accept;
`ifdef PARK_ROUND_ROBIN_EN
    logic [3:0] rr_ptr;
    // rotate the allocation start past each committed entrance
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= 4'd0;
        else if (state == COMMIT && dir)
            rr_ptr <= (idx == 4'(NUM_SLOTS - 1)) ? 4'd0 : idx + 4'd1;
    end
    assign ptr = rr_ptr;
`else
    assign ptr = 4'd0;
`endif
    // request qualification and first free slot at or after ptr, wrapping
    always_comb begin
        occ      = 16'(bus.slot_status);
        exit_ok  = ({1'b0, bus.exit_slot} < 5'(NUM_SLOTS)) && occ[bus.exit_slot];
        lot_full = &bus.slot_status;
        accept   = bus.exit_req ? exit_ok : (bus.entry_req && !lot_full);
        j        = 5'd0;
        free_idx = 4'd0;
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            j = 5'((int'(ptr) + k) % NUM_SLOTS);
            if (!occ[j[3:0]]) free_idx = j[3:0];
        end
    end
    // IDLE -> OPEN -> COMMIT -> SETTLE sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            dir               <= 1'b0;
            idx               <= 4'd0;
            bus.gate_open     <= 1'b0;
            bus.slot_update   <= 4'd0;
            bus.timer_status  <= 1'b0;
            bus.upd_valid     <= 1'b0;
            bus.assigned_slot <= 4'd0;
            bus.entry_denied  <= 1'b0;
            bus.exit_error    <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            bus.entry_denied <= 1'b0;
            bus.exit_error   <= 1'b0;
            bus.upd_valid    <= 1'b0;
            case (state)
                IDLE: begin
                    bus.exit_error   <= bus.exit_req && !exit_ok;
                    bus.entry_denied <= !bus.exit_req && bus.entry_req && lot_full;
                    if (accept) begin
                        state         <= OPEN;
                        cnt           <= CW'(GATE_OPEN_CYCLES - 1);
                        dir           <= !bus.exit_req;
                        idx           <= bus.exit_req ? bus.exit_slot : free_idx;
                        bus.gate_open <= 1'b1;
                        bus.busy      <= 1'b1;
                        if (!bus.exit_req) bus.assigned_slot <= free_idx;
                    end
                end
                OPEN: begin
                    if (cnt == '0) begin
                        state            <= COMMIT;
                        bus.gate_open    <= 1'b0;
                        bus.upd_valid    <= 1'b1;
                        bus.slot_update  <= idx;
                        bus.timer_status <= dir;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                COMMIT: state <= SETTLE;
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
